// File: rtl/axis_pkt_snooper.sv
// ---------------------------------------------------------------------------------------------
// axis_pkt_snooper
//
// Passive AXI-Stream tap. It acquires a packet buffer from the downstream arbiter with a
// rdy/ack handshake. It then copies every observed beat into that buffer as one memory word
// and pulses done at end of packet. The stream is never back-pressured. A packet that starts
// while no buffer is held is dropped and counted. A packet longer than the buffer is
// truncated and counted.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   s_tdata      observed stream data
//   s_tkeep      byte enables, contiguous from LSB
//   s_tlast      last beat of packet
//   s_tvalid     stream valid
//   s_tready     stream ready (observed only); a beat is s_tvalid && s_tready
//   rdy          arbiter has a free buffer
//   ack          buffer acquisition request; handshake completes on rdy && ack
//   done_ack     arbiter done acknowledge (unused; done is fire-and-forget)
//   addr         word address of the current write
//   wr_data      write data
//   wr_en        write strobe
//   byte_inc     valid bytes in this word (popcount of tkeep)
//   done         one-cycle end-of-packet pulse, aligned with the last write
//   drop_cnt     packets dropped, saturating
//   trunc_cnt    packets truncated, saturating
// ---------------------------------------------------------------------------------------------
module axis_pkt_snooper #(
    parameter int unsigned SN_ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 64,  // multiple of 8
    parameter int unsigned INC_WIDTH     = 8,   // must hold DATA_WIDTH/8
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_tdata,
    input  logic [DATA_WIDTH/8-1:0]    s_tkeep,
    input  logic                       s_tlast,
    input  logic                       s_tvalid,
    input  logic                       s_tready,
    input  logic                       rdy,
    output logic                       ack,
    input  logic                       done_ack,
    output logic [SN_ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_en,
    output logic [INC_WIDTH-1:0]       byte_inc,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       drop_cnt,
    output logic [CNT_WIDTH-1:0]       trunc_cnt
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [SN_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        StWaitBuf,  // no buffer held
        StHaveBuf,  // buffer held, no beat of the packet seen yet
        StWriting,  // mid-packet, writing into the held buffer
        StDrop      // discarding the rest of a packet that started without a buffer
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------------------------
    state_e                     r_state;
    logic [SN_ADDR_WIDTH-1:0]   r_wr_ptr;   // address the next beat of this packet lands on
    logic                       r_full;     // last buffer word written, remaining beats discarded
    logic [SN_ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]      r_wr_data;
    logic                       r_wr_en;
    logic [INC_WIDTH-1:0]       r_byte_inc;
    logic                       r_done;
    logic [CNT_WIDTH-1:0]       r_drop_cnt;
    logic [CNT_WIDTH-1:0]       r_trunc_cnt;

    // ---------------------------------------------------------------------------------------
    // Next-state wires
    // ---------------------------------------------------------------------------------------
    state_e                     w_state_nxt;
    logic [SN_ADDR_WIDTH-1:0]   w_wr_ptr_nxt;
    logic                       w_full_nxt;
    logic [SN_ADDR_WIDTH-1:0]   w_addr_nxt;
    logic [DATA_WIDTH-1:0]      w_wr_data_nxt;
    logic                       w_wr_en_nxt;
    logic [INC_WIDTH-1:0]       w_byte_inc_nxt;
    logic                       w_done_nxt;
    logic                       w_drop_inc;
    logic                       w_trunc_inc;

    logic                       w_beat;
    logic                       w_ack;
    logic [SN_ADDR_WIDTH-1:0]   w_cur_addr;
    logic [INC_WIDTH-1:0]       w_popcnt;
    logic                       w_unused;

    assign w_unused = done_ack;

    assign w_beat = s_tvalid && s_tready;

    // A beat in the acquisition cycle belongs to a packet that already started without a
    // buffer, so the request is withheld to keep that packet from being half-captured.
    assign w_ack = rdy && (r_state == StWaitBuf) && !w_beat;

    // The first beat of a packet always lands on word 0 of the freshly acquired buffer.
    assign w_cur_addr = (r_state == StHaveBuf) ? '0 : r_wr_ptr;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_popcnt = w_popcnt + INC_WIDTH'(s_tkeep[i]);
        end
    end

    // ---------------------------------------------------------------------------------------
    // Next-state and write-output logic
    // ---------------------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_full_nxt     = r_full;
        w_addr_nxt     = r_addr;
        w_wr_data_nxt  = r_wr_data;
        w_wr_en_nxt    = 1'b0;
        w_byte_inc_nxt = r_byte_inc;
        w_done_nxt     = 1'b0;
        w_drop_inc     = 1'b0;
        w_trunc_inc    = 1'b0;

        unique case (r_state)
            StWaitBuf: begin
                if (w_beat) begin
                    w_drop_inc = 1'b1;
                    if (!s_tlast) begin
                        w_state_nxt = StDrop;
                    end
                end else if (w_ack) begin
                    w_state_nxt = StHaveBuf;
                end
            end

            StHaveBuf, StWriting: begin
                if (w_beat) begin
                    if (!r_full) begin
                        w_wr_en_nxt    = 1'b1;
                        w_addr_nxt     = w_cur_addr;
                        w_wr_data_nxt  = s_tdata;
                        w_byte_inc_nxt = w_popcnt;
                        w_wr_ptr_nxt   = w_cur_addr + SN_ADDR_WIDTH'(1);
                        if (w_cur_addr == LAST_ADDR) begin
                            w_full_nxt = 1'b1;
                        end
                    end
                    if (s_tlast) begin
                        // A packet that exactly fills the buffer ends with r_full still
                        // clear, so only beats that arrived after the buffer filled count
                        // as truncation.
                        w_done_nxt   = 1'b1;
                        w_trunc_inc  = r_full;
                        w_full_nxt   = 1'b0;
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = StWaitBuf;
                    end else begin
                        w_state_nxt = StWriting;
                    end
                end
            end

            StDrop: begin
                if (w_beat && s_tlast) begin
                    w_state_nxt = StWaitBuf;
                end
            end

            default: begin
                w_state_nxt = StWaitBuf;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StWaitBuf;
            r_wr_ptr   <= '0;
            r_full     <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_byte_inc <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_full     <= w_full_nxt;
            r_addr     <= w_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_byte_inc <= w_byte_inc_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Event counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt  <= '0;
            r_trunc_cnt <= '0;
        end else begin
            if (w_drop_inc && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
            if (w_trunc_inc && (r_trunc_cnt != '1)) begin
                r_trunc_cnt <= r_trunc_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign ack       = w_ack;
    assign addr      = r_addr;
    assign wr_data   = r_wr_data;
    assign wr_en     = r_wr_en;
    assign byte_inc  = r_byte_inc;
    assign done      = r_done;
    assign drop_cnt  = r_drop_cnt;
    assign trunc_cnt = r_trunc_cnt;

endmodule

// File: tb/tb_axis_pkt_snooper.sv
// ---------------------------------------------------------------------------------------------
// tb_axis_pkt_snooper
//
// Directed bench for axis_pkt_snooper with a 4-word buffer (SN_ADDR_WIDTH = 2). Stimulus
// pushes the expected write/done words into a queue as each beat is issued. A negedge
// monitor pops one entry whenever wr_en or done is seen and compares it against the outputs.
// ---------------------------------------------------------------------------------------------
module tb_axis_pkt_snooper;

    localparam int AW = 2;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int IW = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic          rdy;
    logic          ack;
    logic          done_ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic [IW-1:0] byte_inc;
    logic          done;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] trunc_cnt;

    axis_pkt_snooper #(
        .SN_ADDR_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .INC_WIDTH     (IW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .rdy       (rdy),
        .ack       (ack),
        .done_ack  (done_ack),
        .addr      (addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .byte_inc  (byte_inc),
        .done      (done),
        .drop_cnt  (drop_cnt),
        .trunc_cnt (trunc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr_en;
        logic          done;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IW-1:0] inc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ack_cnt  = 0;
    bit   ack_win  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: every write or done pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en || done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got wr_en=%0b done=%0b addr=%0h expected none (t=%0t)",
                         wr_en, done, addr, $time);
            end else begin
                e = exp_q.pop_front();
                check("mon_wr_en", 64'(wr_en), 64'(e.wr_en));
                check("mon_done", 64'(done), 64'(e.done));
                if (e.wr_en) begin
                    check("mon_addr", 64'(addr), 64'(e.addr));
                    check("mon_data", wr_data, e.data);
                    check("mon_byte_inc", 64'(byte_inc), 64'(e.inc));
                end
            end
        end
        if (ack_win && ack) ack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one stream cycle; queue the expected output if it should produce one.
    task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                         input logic rd, input bit ew, input bit ed, input int ea,
                         input int ei);
        exp_t e;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        s_tready = rd;
        if (ew || ed) begin
            e.wr_en = ew;
            e.done  = ed;
            e.addr  = AW'(ea);
            e.data  = d;
            e.inc   = IW'(ei);
            exp_q.push_back(e);
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                        input logic rd, input bit ew, input bit ed, input int ea,
                        input int ei);
        drive(d, k, l, rd, ew, ed, ea, ei);
        tick();
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst      = 1'b1;
        rdy      = 1'b0;
        done_ack = 1'b0;
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        tick();
        tick();
        check("rst_wr_en", 64'(wr_en), 0);
        check("rst_done", 64'(done), 0);
        check("rst_addr", 64'(addr), 0);
        check("rst_byte_inc", 64'(byte_inc), 0);
        check("rst_drop_cnt", 64'(drop_cnt), 0);
        check("rst_trunc_cnt", 64'(trunc_cnt), 0);

        // 1: buffer acquired after reset, 3-beat packet with a partial last word.
        rst     = 1'b0;
        rdy     = 1'b1;
        ack_win = 1'b1;
        #1;
        check("t1_ack_request", 64'(ack), 1);
        tick();
        check("t1_ack_after_grant", 64'(ack), 0);
        tick();
        beat(64'h1111_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8);
        beat(64'h1111_0000_0000_0002, 8'hFF, 1'b0, 1'b1, 1, 0, 1, 8);
        beat(64'h1111_0000_0000_0003, 8'h0F, 1'b1, 1'b1, 1, 1, 2, 4);
        ack_win = 1'b0;
        rdy     = 1'b0;
        check("t1_ack_cycles", 64'(ack_cnt), 1);
        check("t1_drop_cnt", 64'(drop_cnt), 0);

        // 2: packet with no buffer is dropped; next packet after a grant is captured.
        idle(1);
        beat(64'h2222_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 0, 0, 0, 0);
        beat(64'h2222_0000_0000_0002, 8'hFF, 1'b1, 1'b1, 0, 0, 0, 0);
        rdy = 1'b1;
        idle(1);
        beat(64'h2222_0000_0000_0003, 8'h03, 1'b1, 1'b1, 1, 1, 0, 2);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        check("t2_done_cycle_done", 64'(done), 1);
        check("t2_done_cycle_ack", 64'(ack), 1);
        check("t2_drop_cnt", 64'(drop_cnt), 1);
        tick();  // handshake completes on the done cycle

        // 3: 6-beat packet into a 4-word buffer truncates; exact 4-beat packet does not.
        beat(64'h3333_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8);
        beat(64'h3333_0000_0000_0002, 8'hFF, 1'b0, 1'b1, 1, 0, 1, 8);
        beat(64'h3333_0000_0000_0003, 8'hFF, 1'b0, 1'b1, 1, 0, 2, 8);
        beat(64'h3333_0000_0000_0004, 8'hFF, 1'b0, 1'b1, 1, 0, 3, 8);
        beat(64'h3333_0000_0000_0005, 8'hFF, 1'b0, 1'b1, 0, 0, 0, 0);
        beat(64'h3333_0000_0000_0006, 8'hFF, 1'b1, 1'b1, 0, 1, 0, 0);
        check("t3_trunc_cnt", 64'(trunc_cnt), 1);
        idle(1);
        beat(64'h3434_0000_0000_0001, 8'h01, 1'b0, 1'b1, 1, 0, 0, 1);
        beat(64'h3434_0000_0000_0002, 8'h07, 1'b0, 1'b1, 1, 0, 1, 3);
        beat(64'h3434_0000_0000_0003, 8'h3F, 1'b0, 1'b1, 1, 0, 2, 6);
        beat(64'h3434_0000_0000_0004, 8'h7F, 1'b1, 1'b1, 1, 1, 3, 7);
        check("t3_exact_fit_trunc_cnt", 64'(trunc_cnt), 1);

        // 4: back-to-back packets; the second starts on the done cycle and is dropped.
        idle(1);
        beat(64'h4444_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8);
        beat(64'h4444_0000_0000_0002, 8'hFF, 1'b1, 1'b1, 1, 1, 1, 8);
        drive(64'h4545_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 0, 0, 0, 0);
        #1;
        check("t4_ack_suppressed", 64'(ack), 0);
        check("t4_done_with_beat", 64'(done), 1);
        tick();
        beat(64'h4545_0000_0000_0002, 8'hFF, 1'b1, 1'b1, 0, 0, 0, 0);
        check("t4_drop_cnt", 64'(drop_cnt), 2);

        // 5: stalled cycles (tready=0) are not beats; all-zero tkeep gives byte_inc 0.
        idle(1);
        beat(64'h5555_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8);
        beat(64'h5555_DEAD_0000_0000, 8'hFF, 1'b0, 1'b0, 0, 0, 0, 0);
        beat(64'h5555_0000_0000_0002, 8'h00, 1'b1, 1'b1, 1, 1, 1, 0);
        beat(64'h5555_DEAD_0000_0001, 8'hFF, 1'b0, 1'b0, 0, 0, 0, 0);
        s_tvalid = 1'b0;
        check("t5_drop_cnt", 64'(drop_cnt), 2);

        // 6: reset on beat 2 of 4; the tail is dropped and the next packet starts at 0.
        beat(64'h6666_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8);
        drive(64'h6666_0000_0000_0002, 8'hFF, 1'b0, 1'b1, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        check("t6_rst_wr_en", 64'(wr_en), 0);
        check("t6_rst_done", 64'(done), 0);
        check("t6_rst_addr", 64'(addr), 0);
        check("t6_rst_wr_data", wr_data, 0);
        check("t6_rst_trunc_cnt", 64'(trunc_cnt), 0);
        check("t6_rst_drop_cnt", 64'(drop_cnt), 0);
        rst = 1'b0;
        beat(64'h6666_0000_0000_0003, 8'hFF, 1'b0, 1'b1, 0, 0, 0, 0);
        beat(64'h6666_0000_0000_0004, 8'hFF, 1'b1, 1'b1, 0, 0, 0, 0);
        check("t6_drop_cnt", 64'(drop_cnt), 1);
        idle(1);
        beat(64'h6767_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8);
        beat(64'h6767_0000_0000_0002, 8'h1F, 1'b1, 1'b1, 1, 1, 1, 5);
        idle(3);
        check("queue_drained", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
